// File: rtl/return_addr_stack_pkg.sv
// ---------------------------------------------------------------------------
// return_addr_stack_pkg
//
// Shared definitions for the return-address stack and the PC-select path.
//   ADDR_WIDTH : default return-address width in bits
//   RAS_DEPTH  : default number of stack entries
//   ras_op_e   : the single action the stack takes on a clock edge
//   ras_decode : maps the request lines and stack status onto ras_op_e
// ---------------------------------------------------------------------------
package return_addr_stack_pkg;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned RAS_DEPTH  = 8;

  // Every combination of flush/push/pop and full/empty collapses onto
  // exactly one of these actions, so the datapath only has to look at one
  // value. RAS_PUSH_UNF is a push onto an empty stack that also carried a
  // pop: the pop is dropped and flagged, but the push still lands.
  typedef enum logic [2:0] {
    RAS_HOLD     = 3'd0,
    RAS_FLUSH    = 3'd1,
    RAS_PUSH     = 3'd2,
    RAS_POP      = 3'd3,
    RAS_REPLACE  = 3'd4,
    RAS_PUSH_UNF = 3'd5,
    RAS_OVF      = 3'd6,
    RAS_UNF      = 3'd7
  } ras_op_e;

  // Flush outranks any push/pop in the same cycle. Push+pop on a non-empty
  // stack (full included) replaces the top entry in place, so it can never
  // overflow.
  function automatic ras_op_e ras_decode(input logic flush,
                                         input logic push,
                                         input logic pop,
                                         input logic full,
                                         input logic empty);
    ras_op_e op;
    op = RAS_HOLD;
    if (flush) begin
      op = RAS_FLUSH;
    end else if (push && pop) begin
      op = empty ? RAS_PUSH_UNF : RAS_REPLACE;
    end else if (push) begin
      op = full ? RAS_OVF : RAS_PUSH;
    end else if (pop) begin
      op = empty ? RAS_UNF : RAS_POP;
    end
    return op;
  endfunction

endpackage

// File: rtl/ras_regfile.sv
// ---------------------------------------------------------------------------
// ras_regfile
//
// DEPTH x WIDTH register array backing the return-address stack.
// One synchronous write port and one combinational read port. The contents
// are not reset: the stack pointer alone decides which entries are valid.
//
// Ports:
//   clk    : rising-edge clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : combinational read data at raddr
// ---------------------------------------------------------------------------
module ras_regfile #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single write port; storage carries no reset because stale entries
  // above the stack pointer are never observed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // DEPTH is a power of two, so every raddr value names a real entry.
  assign rdata = mem[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// ---------------------------------------------------------------------------
// return_addr_stack
//
// Hardware return-address stack. CALL pushes the return PC, RET pops it,
// and the current top entry feeds the "return" leg of the next-PC mux.
// The stack never wraps: pushing while full and popping while empty are
// dropped and recorded in sticky error flags that only reset clears.
//
// Ports:
//   clk       : rising-edge clock
//   reset     : synchronous, active-high; clears pointer and flags
//   push      : push push_data this cycle
//   push_data : return address to push
//   pop       : remove the top entry this cycle
//   flush     : discard all entries, flags untouched
//   top       : current top entry, 0 when empty
//   count     : number of valid entries, 0..DEPTH
//   full      : count == DEPTH
//   empty     : count == 0
//   overflow  : sticky, a push was attempted while full
//   underflow : sticky, a pop was attempted while empty
// ---------------------------------------------------------------------------
module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int unsigned WIDTH = ADDR_WIDTH,
  parameter int unsigned DEPTH = RAS_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       top,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // sp is one wider than the address so it can hold DEPTH itself.
  logic [CW-1:0]    sp;
  logic [CW-1:0]    sp_next;
  logic [AW-1:0]    top_addr;
  logic [WIDTH-1:0] top_raw;
  logic             we;
  logic [AW-1:0]    waddr;
  logic             ovf_set;
  logic             unf_set;
  ras_op_e          op;

  // Status comes straight from the registered pointer, so there is no
  // combinational path from push/pop to any output.
  assign full  = (sp == CW'(DEPTH));
  assign empty = (sp == '0);
  assign count = sp;

  // sp-1 wraps to all ones when empty; the read is masked to 0 below.
  assign top_addr = AW'(sp - CW'(1));
  assign top      = empty ? '0 : top_raw;

  // Collapse the request lines and stack status into one action per edge.
  always_comb begin
    op = ras_decode(flush, push, pop, full, empty);
  end

  // Translate the chosen action into a storage write, the next pointer and
  // any error flag to raise. Reset suppresses the write so a push held
  // during reset cannot touch storage.
  always_comb begin
    we      = 1'b0;
    waddr   = sp[AW-1:0];
    sp_next = sp;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (op)
      RAS_FLUSH: begin
        sp_next = '0;
      end
      RAS_PUSH: begin
        we      = 1'b1;
        sp_next = sp + CW'(1);
      end
      RAS_POP: begin
        sp_next = sp - CW'(1);
      end
      RAS_REPLACE: begin
        we    = 1'b1;
        waddr = top_addr;
      end
      RAS_PUSH_UNF: begin
        we      = 1'b1;
        waddr   = '0;
        sp_next = CW'(1);
        unf_set = 1'b1;
      end
      RAS_OVF: begin
        ovf_set = 1'b1;
      end
      RAS_UNF: begin
        unf_set = 1'b1;
      end
      default: begin
        sp_next = sp;
      end
    endcase
    if (reset) begin
      we = 1'b0;
    end
  end

  // Pointer and sticky flags. Reset wins over everything; after that the
  // flags only ever accumulate.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_next;
      overflow  <= overflow | ovf_set;
      underflow <= underflow | unf_set;
    end
  end

  ras_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (push_data),
    .raddr (top_addr),
    .rdata (top_raw)
  );

endmodule

// File: tb/tb_return_addr_stack.sv
// ---------------------------------------------------------------------------
// tb_return_addr_stack
//
// Self-checking bench for return_addr_stack. A queue-based model of the
// stack tracks the expected contents and sticky flags; directed scenarios
// follow the stack's documented behaviour and a randomized run compares
// every output against the model each cycle.
// ---------------------------------------------------------------------------
module tb_return_addr_stack;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;

  logic             clk;
  logic             reset;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             pop;
  logic             flush;
  logic [WIDTH-1:0] top;
  logic [3:0]       count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  int total;
  int bad;

  logic [WIDTH-1:0] model_q[$];
  logic             model_ovf;
  logic             model_unf;

  return_addr_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .top       (top),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [WIDTH-1:0] exp_top();
    return (model_q.size() != 0) ? model_q[model_q.size()-1] : '0;
  endfunction

  // Advance one rising edge with whatever inputs are currently driven,
  // update the reference model from those inputs, then return to the
  // falling edge with all requests deasserted.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      model_q.delete();
      model_ovf = 1'b0;
      model_unf = 1'b0;
    end else if (flush) begin
      model_q.delete();
    end else if (push && pop) begin
      if (model_q.size() == 0) begin
        model_unf = 1'b1;
        model_q.push_back(push_data);
      end else begin
        model_q[model_q.size()-1] = push_data;
      end
    end else if (push) begin
      if (model_q.size() == DEPTH) model_ovf = 1'b1;
      else model_q.push_back(push_data);
    end else if (pop) begin
      if (model_q.size() == 0) model_unf = 1'b1;
      else void'(model_q.pop_back());
    end
    @(negedge clk);
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
  endtask

  task automatic drive(input logic r, input logic p, input logic [WIDTH-1:0] d,
                       input logic q, input logic f);
    reset     = r;
    push      = p;
    push_data = d;
    pop       = q;
    flush     = f;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; push = 1'b1; pop = 1'b1; flush = 1'b0; push_data = 16'hBEEF;
    step();
    reset = 1'b1; push = 1'b1; pop = 1'b1; push_data = 16'h1234;
    step();
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b want=0", full); end
    total++; if (top !== 16'h0000) begin bad++; $display("[TB] FAIL reset_top got=%h want=0000", top); end
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("[TB] FAIL reset_flags got=%b want=00", {overflow, underflow}); end
  endtask

  task automatic test_lifo();
    logic [WIDTH-1:0] expv [3];
    expv[0] = 16'h0030; expv[1] = 16'h0020; expv[2] = 16'h0010;
    drive(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
    total++; if (top !== 16'h0010) begin bad++; $display("[TB] FAIL push_visible got=%h want=0010", top); end
    drive(1'b0, 1'b1, 16'h0020, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0030, 1'b0, 1'b0);
    total++; if (count !== 4'd3) begin bad++; $display("[TB] FAIL lifo_count got=%0d want=3", count); end
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1;
      #1;
      total++; if (top !== expv[i]) begin bad++; $display("[TB] FAIL lifo_pop%0d got=%h want=%h", i, top, expv[i]); end
      step();
    end
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL lifo_empty got=%b want=1", empty); end
    total++; if (underflow !== 1'b0) begin bad++; $display("[TB] FAIL lifo_underflow got=%b want=0", underflow); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    end
    total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL ovf_full got=%b want=1", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_early got=%b want=0", overflow); end
    drive(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    total++; if (count !== 4'd8) begin bad++; $display("[TB] FAIL ovf_count got=%0d want=8", count); end
    total++; if (top !== 16'h0107) begin bad++; $display("[TB] FAIL ovf_top got=%h want=0107", top); end
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag got=%b want=1", overflow); end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    total++; if (top !== 16'h0106) begin bad++; $display("[TB] FAIL ovf_pop_top got=%h want=0106", top); end
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky got=%b want=1", overflow); end
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_reset_clear got=%b want=0", overflow); end
  endtask

  task automatic test_replace();
    drive(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0020, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0030, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0040, 1'b1, 1'b0);
    total++; if (count !== 4'd3) begin bad++; $display("[TB] FAIL replace_count got=%0d want=3", count); end
    total++; if (top !== 16'h0040) begin bad++; $display("[TB] FAIL replace_top got=%h want=0040", top); end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    total++; if (top !== 16'h0020) begin bad++; $display("[TB] FAIL replace_pop got=%h want=0020", top); end
    total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("[TB] FAIL replace_flags got=%b want=00", {overflow, underflow}); end
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    total++; if (underflow !== 1'b0) begin bad++; $display("[TB] FAIL unf_pre got=%b want=0", underflow); end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    total++; if (underflow !== 1'b1) begin bad++; $display("[TB] FAIL unf_flag got=%b want=1", underflow); end
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL unf_count got=%0d want=0", count); end
    drive(1'b0, 1'b1, 16'h0055, 1'b1, 1'b0);
    total++; if (count !== 4'd1) begin bad++; $display("[TB] FAIL unf_pushpop_count got=%0d want=1", count); end
    total++; if (top !== 16'h0055) begin bad++; $display("[TB] FAIL unf_pushpop_top got=%h want=0055", top); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 16'h0060 + 16'(i), 1'b0, 1'b0);
    end
    total++; if (count !== 4'd5) begin bad++; $display("[TB] FAIL flush_pre_count got=%0d want=5", count); end
    drive(1'b0, 1'b1, 16'h0099, 1'b0, 1'b1);
    total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL flush_count got=%0d want=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL flush_empty got=%b want=1", empty); end
    total++; if (top !== 16'h0000) begin bad++; $display("[TB] FAIL flush_top got=%h want=0000", top); end
    total++; if ({overflow, underflow} !== 2'b01) begin bad++; $display("[TB] FAIL flush_flags got=%b want=01", {overflow, underflow}); end
    drive(1'b0, 1'b1, 16'h0077, 1'b0, 1'b0);
    total++; if (top !== 16'h0077) begin bad++; $display("[TB] FAIL flush_push_top got=%h want=0077", top); end
  endtask

  task automatic test_random();
    logic [WIDTH+7:0] got;
    logic [WIDTH+7:0] want;
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      push      = ($urandom_range(0, 99) < 55);
      pop       = ($urandom_range(0, 99) < 45);
      push_data = 16'($urandom);
      #1;
      total++;
      if (top !== exp_top()) begin
        bad++;
        $display("[TB] FAIL rand_pre_top cycle=%0d got=%h want=%h", n, top, exp_top());
      end
      step();
      got  = {top, 4'(count), full, empty, overflow, underflow};
      want = {exp_top(), 4'(model_q.size()), model_q.size() == DEPTH,
              model_q.size() == 0, model_ovf, model_unf};
      total++;
      if (got !== want) begin
        bad++;
        $display("[TB] FAIL rand_state cycle=%0d got=%h want=%h", n, got, want);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_ovf = 1'b0;
    model_unf = 1'b0;
    reset = 1'b1; push = 1'b1; pop = 1'b1; flush = 1'b0; push_data = '0;
    @(negedge clk);
    test_reset();
    test_lifo();
    test_overflow();
    test_replace();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    test_underflow();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
